// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
//   Single-clock FIFO with configurable width and depth, registered level and
//   status flags, sticky overflow/underflow indicators, and a choice between a
//   registered read port and a first-word-fall-through read port.
//
// Parameters
//   DATASIZE   : word width in bits
//   ADDRSIZE   : address bits, depth = 2**ADDRSIZE
//   FWFT       : 0 = RDATA_O loads the popped word one cycle after a read
//                1 = RDATA_O shows the head word whenever the FIFO is not empty
//   AFULL_THR  : AWFULL_O is high while LEVEL_O >= AFULL_THR
//   AEMPTY_THR : AREMPTY_O is high while LEVEL_O <= AEMPTY_THR
//
// Ports
//   CLK_I     in   clock, all state changes on the rising edge
//   RST_I     in   synchronous active-high reset
//   WDATA_I   in   write data
//   WINC_I    in   write request
//   WFULL_O   out  FIFO full
//   AWFULL_O  out  almost full
//   RINC_I    in   read request
//   RDATA_O   out  read data
//   REMPTY_O  out  FIFO empty
//   AREMPTY_O out  almost empty
//   LEVEL_O   out  occupancy, 0 .. 2**ADDRSIZE
//   OVF_O     out  sticky: write attempted while full
//   UDF_O     out  sticky: read attempted while empty
// -----------------------------------------------------------------------------
module fifo_sync_param #(
    parameter int DATASIZE   = 8,
    parameter int ADDRSIZE   = 4,
    parameter int FWFT       = 0,
    parameter int AFULL_THR  = (1 << ADDRSIZE) - 2,
    parameter int AEMPTY_THR = 2
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic [DATASIZE-1:0] WDATA_I,
    input  logic                WINC_I,
    output logic                WFULL_O,
    output logic                AWFULL_O,
    input  logic                RINC_I,
    output logic [DATASIZE-1:0] RDATA_O,
    output logic                REMPTY_O,
    output logic                AREMPTY_O,
    output logic [ADDRSIZE:0]   LEVEL_O,
    output logic                OVF_O,
    output logic                UDF_O
);

    localparam int                DEPTH      = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] FULL_LVL   = (ADDRSIZE + 1)'(DEPTH);
    localparam logic [ADDRSIZE:0] AFULL_LVL  = (ADDRSIZE + 1)'(AFULL_THR);
    localparam logic [ADDRSIZE:0] AEMPTY_LVL = (ADDRSIZE + 1)'(AEMPTY_THR);
    localparam logic [ADDRSIZE:0] ONE        = (ADDRSIZE + 1)'(1);

    logic [DATASIZE-1:0] mem [DEPTH];

    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE:0]   rptr;
    logic [ADDRSIZE:0]   rptr_next;
    logic [ADDRSIZE:0]   level;
    logic [DATASIZE-1:0] rdata;
    logic                ovf;
    logic                udf;
    logic                full;
    logic                empty;
    logic                wr_en;
    logic                rd_en;

    // Flags decode the registered level, so they are glitch-free and
    // consistent with LEVEL_O in every cycle.
    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);

    // A write while full or a read while empty is dropped; that also resolves
    // the simultaneous read+write corner cases at the two boundaries.
    assign wr_en = WINC_I && !full  && !RST_I;
    assign rd_en = RINC_I && !empty && !RST_I;

    assign rptr_next = rd_en ? rptr + ONE : rptr;

    // NOTE: the storage array has no reset; the pointers define which words
    // are valid, so clearing them is enough to discard the contents and the
    // array can map onto plain RAM.
    always_ff @(posedge CLK_I) begin
        if (wr_en) begin
            mem[wptr[ADDRSIZE-1:0]] <= WDATA_I;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the values from before the clock edge.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + ONE;
            end
            rptr <= rptr_next;

            case ({wr_en, rd_en})
                2'b10:   level <= level + ONE;
                2'b01:   level <= level - ONE;
                default: level <= level;
            endcase

            if (WINC_I && full) begin
                ovf <= 1'b1;
            end
            if (RINC_I && empty) begin
                udf <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // The output register is reloaded every cycle with whatever will
            // be the head word after this edge. When that slot is being
            // written in the same cycle (first write into an empty FIFO, or
            // read+write at level 1), the array does not hold it yet, so the
            // incoming word is forwarded instead.
            logic [ADDRSIZE-1:0] head_idx;
            logic                bypass;

            assign head_idx = rptr_next[ADDRSIZE-1:0];
            assign bypass   = wr_en && (wptr[ADDRSIZE-1:0] == head_idx);

            always_ff @(posedge CLK_I) begin
                if (RST_I) begin
                    rdata <= '0;
                end else begin
                    rdata <= bypass ? WDATA_I : mem[head_idx];
                end
            end
        end else begin : g_reg
            // A read can only target a slot already written in an earlier
            // cycle (the FIFO is not empty and a full FIFO drops writes), so
            // no forwarding is needed here.
            always_ff @(posedge CLK_I) begin
                if (RST_I) begin
                    rdata <= '0;
                end else if (rd_en) begin
                    rdata <= mem[rptr[ADDRSIZE-1:0]];
                end
            end
        end
    endgenerate

    assign RDATA_O   = rdata;
    assign LEVEL_O   = level;
    assign WFULL_O   = full;
    assign REMPTY_O  = empty;
    assign AWFULL_O  = (level >= AFULL_LVL);
    assign AREMPTY_O = (level <= AEMPTY_LVL);
    assign OVF_O     = ovf;
    assign UDF_O     = udf;

endmodule
